// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array controller and its drain path.
package systolic_pkg;

  localparam int DEF_NUM_PE = 4;
  localparam int DEF_ACC_W  = 8;
  localparam int DEF_IDX_W  = $clog2(DEF_NUM_PE);

  // One drained result as it sits in the drain FIFO (default configuration).
  typedef struct packed {
    logic [DEF_ACC_W-1:0] data;
    logic [DEF_IDX_W-1:0] idx;
    logic                 last;
  } drain_entry_t;

  // Controller phases; a top level derives cap_valid = (state == ST_DRAIN).
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/systolic_fifo.sv
// Generic register-based synchronous FIFO with explicit occupancy count.
// Flush has priority over push and pop; the head is read combinationally.
module systolic_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is reset so the head output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/systolic_drain_buffer.sv
// Captures drained PE results, applies optional ReLU, tags them with index/last
// and buffers them for a valid/ready consumer; tracks overflow and order errors.
module systolic_drain_buffer
  import systolic_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DEPTH  = 8,
  localparam int IDX_W = $clog2(NUM_PE),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_valid,
  input  logic [IDX_W-1:0] cap_idx,
  input  logic [ACC_W-1:0] cap_data,
  input  logic             relu_en,
  input  logic             flush,
  input  logic             clr_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow,
  output logic             seq_err
);

  // Stream handshake: a result transfers on a cycle where out_valid && out_ready.
  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } entry_t;

  entry_t           wr_entry, rd_entry;
  logic             push, pop, fifo_full, fifo_empty;
  logic             ovf_event, seq_event;
  logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
  logic             overflow_q, overflow_d;
  logic             seq_err_q, seq_err_d;

  always_comb begin
    pop  = !fifo_empty && out_ready;
    push = cap_valid && (!fifo_full || pop) && !flush;

    wr_entry.data = (relu_en && cap_data[ACC_W-1]) ? '0 : cap_data;
    wr_entry.idx  = cap_idx;
    wr_entry.last = (cap_idx == IDX_W'(NUM_PE - 1));

    // A flushed capture is discarded entirely, so it raises no error either.
    ovf_event = cap_valid && fifo_full && !pop && !flush;
    seq_event = cap_valid && !flush && (cap_idx != exp_idx_q);

    exp_idx_d = exp_idx_q;
    if (flush)          exp_idx_d = '0;
    else if (cap_valid) exp_idx_d = cap_idx + IDX_W'(1);

    overflow_d = (overflow_q && !clr_err) || ovf_event;
    seq_err_d  = (seq_err_q && !clr_err) || seq_event;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_idx_q  <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      exp_idx_q  <= exp_idx_d;
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
    end
  end

  systolic_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = rd_entry.data;
  assign out_idx   = rd_entry.idx;
  assign out_last  = rd_entry.last;
  assign full      = fifo_full;
  assign overflow  = overflow_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_systolic_drain_buffer.sv
// Bench for systolic_drain_buffer: directed frames plus random traffic checked
// each cycle against a queue-based reference model.
module tb_systolic_drain_buffer;

  localparam int NPE   = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_valid, relu_en, flush, clr_err, out_ready;
  logic [IW-1:0] cap_idx;
  logic [AW-1:0] cap_data;
  logic          out_valid, out_last, full, overflow, seq_err;
  logic [AW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  systolic_drain_buffer #(.NUM_PE(NPE), .ACC_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_idx(cap_idx),
    .cap_data(cap_data), .relu_en(relu_en), .flush(flush), .clr_err(clr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .count(count), .full(full),
    .overflow(overflow), .seq_err(seq_err)
  );

  typedef struct {
    logic [AW-1:0] data;
    int            idx;
    bit            last;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf, m_seq;
  int   m_exp;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(mq[0].data));
      chk("out_idx",  32'(out_idx),  32'(mq[0].idx));
      chk("out_last", 32'(out_last), 32'(mq[0].last));
    end
    chk("count",    32'(count),    32'(mq.size()));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("seq_err",  32'(seq_err),  32'(m_seq));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_full"},      32'(full),      32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'd0);
    chk({tag, "_seq_err"},   32'(seq_err),   32'd0);
  endtask

  // Drive one cycle at the negedge, check current outputs, advance the model.
  task automatic cycle(input bit v, input int idx, input logic [AW-1:0] d, input bit relu,
                       input bit rdy, input bit fl, input bit clr);
    bit   pop, ev_ovf, ev_seq;
    ent_t e;
    cap_valid = v; cap_idx = IW'(idx); cap_data = d; relu_en = relu;
    out_ready = rdy; flush = fl; clr_err = clr;
    #1;
    check_outputs();
    pop = (mq.size() != 0) && rdy;
    ev_ovf = 1'b0;
    ev_seq = 1'b0;
    if (fl) begin
      mq.delete();
      m_exp = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (v) begin
        ev_seq = (idx != m_exp);
        m_exp  = (idx + 1) % NPE;
        if (mq.size() < DEPTH) begin
          e.data = (relu && d[AW-1]) ? '0 : d;
          e.idx  = idx;
          e.last = (idx == NPE - 1);
          mq.push_back(e);
        end else begin
          ev_ovf = 1'b1;
        end
      end
    end
    m_ovf = (m_ovf && !clr) || ev_ovf;
    m_seq = (m_seq && !clr) || ev_seq;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  logic [AW-1:0] frame_data [NPE];

  initial begin
    frame_data[0] = 8'h05; frame_data[1] = 8'hFB; frame_data[2] = 8'h7F; frame_data[3] = 8'h80;
    cap_valid = 0; cap_idx = '0; cap_data = '0; relu_en = 0;
    out_ready = 0; flush = 0; clr_err = 0;
    m_ovf = 0; m_seq = 0; m_exp = 0;
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, then the same frame through ReLU.
    for (int i = 0; i < NPE; i++) cycle(1'b1, i, frame_data[i], 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);
    for (int i = 0; i < NPE; i++) cycle(1'b1, i, frame_data[i], 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 2);

    // Three frames into a stalled consumer, then drain.
    for (int i = 0; i < 3 * NPE; i++)
      cycle(1'b1, i % NPE, AW'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, DEPTH + 2);

    // Full with simultaneous push and pop.
    cycle(1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, i % NPE, AW'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, DEPTH + 1);

    // Out-of-order index, clear, then a clean frame.
    cycle(1'b1, 0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 2, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1);
    cycle(1'b0, 0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NPE; i++) cycle(1'b1, i, AW'(8'hA0 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 5);

    // Flush with a concurrent capture.
    for (int i = 0; i < 5; i++) cycle(1'b1, (i + 1) % NPE, AW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, m_exp, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cap_valid = 1'b1; cap_idx = 2'd2; cap_data = 8'h33;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    cap_valid = 1'b0;
    mq.delete();
    m_ovf = 0; m_seq = 0; m_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle(1'b1, 1);

    // Random traffic, mostly in order with occasional index glitches.
    for (int n = 0; n < 400; n++) begin
      int idx;
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NPE - 1)) : m_exp;
      cycle($urandom_range(0, 3) != 0, idx, AW'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
    end
    idle(1'b1, DEPTH + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
